// File: rtl/mic_pkg.sv
// Shared types for the microsequencer: microinstruction layout, FSM states
// and default widths.
package mic_pkg;

    localparam int unsigned ADDR_W_DEFAULT = 9;
    localparam int unsigned UI_W_DEFAULT   = 36;
    localparam int unsigned NA_W           = 9;
    localparam int unsigned ALU_W          = 6;
    localparam int unsigned C_W            = 9;
    localparam int unsigned B_W            = 4;
    localparam int unsigned MBR_W          = 8;

    // Field order is MSB first, matching the control-store word layout.
    typedef struct packed {
        logic [NA_W-1:0]  next_address;
        logic             jmpc;
        logic             jamn;
        logic             jamz;
        logic             sll8;
        logic             sra1;
        logic [ALU_W-1:0] alu;
        logic [C_W-1:0]   c;
        logic             write;
        logic             read;
        logic             fetch;
        logic [B_W-1:0]   b;
    } micro_t;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        EXEC,
        WAIT_MEM,
        HALT
    } state_t;

endpackage

// File: rtl/mic_next_addr.sv
// Next-MPC computation: pure OR of NEXT_ADDRESS, the JAM high bit and the
// zero-extended MBR byte; no carries.
module mic_next_addr
    import mic_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEFAULT
) (
    input  logic [NA_W-1:0]   next_address,
    input  logic              jmpc,
    input  logic              jamn,
    input  logic              jamz,
    input  logic              alu_n,
    input  logic              alu_z,
    input  logic [MBR_W-1:0]  mbr,
    output logic [ADDR_W-1:0] next_mpc
);

    logic jam;

    always_comb begin
        jam      = (jamn & alu_n) | (jamz & alu_z);
        next_mpc = ADDR_W'(next_address)
                 | ADDR_W'({jam, 8'b0})
                 | (jmpc ? ADDR_W'({1'b0, mbr}) : '0);
    end

endmodule

// File: rtl/mic_microsequencer.sv
// Two-cycle microsequencer: ISSUE latches the microinstruction, EXEC drives
// the datapath controls and resolves the next MPC, WAIT_MEM stalls on memory.
module mic_microsequencer
    import mic_pkg::*;
#(
    parameter int unsigned          ADDR_W    = ADDR_W_DEFAULT,
    parameter int unsigned          UI_W      = UI_W_DEFAULT,
    parameter logic [ADDR_W-1:0]    HALT_ADDR = ADDR_W'('h1FF)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [ADDR_W-1:0] cs_addr,
    input  logic [UI_W-1:0]   cs_data,
    input  logic              alu_n,
    input  logic              alu_z,
    input  logic [7:0]        mbr,
    input  logic              mem_ready,
    output logic [5:0]        alu_ctl,
    output logic [1:0]        shift_ctl,
    output logic [8:0]        c_en,
    output logic [3:0]        b_sel,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic              mem_fetch,
    output logic              halted
);

    state_t            state;
    logic [ADDR_W-1:0] mpc;
    logic [ADDR_W-1:0] next_mpc;
    micro_t            ir;
    logic              n_flag;
    logic              z_flag;
    logic              any_strobe;
    logic              exec;

    // N/Z are architectural state with no consumer inside this block.
    logic unused_flags;
    assign unused_flags = n_flag ^ z_flag;

    mic_next_addr #(.ADDR_W(ADDR_W)) u_next_addr (
        .next_address (ir.next_address),
        .jmpc         (ir.jmpc),
        .jamn         (ir.jamn),
        .jamz         (ir.jamz),
        .alu_n        (alu_n),
        .alu_z        (alu_z),
        .mbr          (mbr),
        .next_mpc     (next_mpc)
    );

    assign any_strobe = ir.read | ir.write | ir.fetch;

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            mpc    <= '0;
            ir     <= '0;
            n_flag <= 1'b0;
            z_flag <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) state <= ISSUE;
                ISSUE: begin
                    ir    <= cs_data;
                    state <= EXEC;
                end
                EXEC: begin
                    mpc    <= next_mpc;
                    n_flag <= alu_n;
                    z_flag <= alu_z;
                    if (any_strobe && !mem_ready) state <= WAIT_MEM;
                    else if (next_mpc == HALT_ADDR) state <= HALT;
                    else state <= ISSUE;
                end
                // MPC already holds the resolved target, so the halt test uses it.
                WAIT_MEM: if (mem_ready) state <= (mpc == HALT_ADDR) ? HALT : ISSUE;
                HALT: if (start) begin
                    mpc   <= '0;
                    state <= ISSUE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign exec      = (state == EXEC);
    assign cs_addr   = mpc;
    assign halted    = (state == HALT);
    assign alu_ctl   = exec ? ir.alu : '0;
    assign shift_ctl = exec ? {ir.sll8, ir.sra1} : '0;
    assign c_en      = exec ? ir.c : '0;
    assign b_sel     = exec ? ir.b : '0;
    assign mem_rd    = exec & ir.read;
    assign mem_wr    = exec & ir.write;
    assign mem_fetch = exec & ir.fetch;

endmodule

// File: tb/tb_mic_microsequencer.sv
// Cycle-level bench for mic_microsequencer: expected per-cycle outputs are
// queued as stimulus is applied and compared at the following falling edge.
module tb_mic_microsequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [8:0]  cs_addr;
    logic [35:0] cs_data;
    logic        alu_n = 1'b0;
    logic        alu_z = 1'b0;
    logic [7:0]  mbr = 8'h00;
    logic        mem_ready = 1'b0;
    logic [5:0]  alu_ctl;
    logic [1:0]  shift_ctl;
    logic [8:0]  c_en;
    logic [3:0]  b_sel;
    logic        mem_rd, mem_wr, mem_fetch, halted;

    logic [35:0] rom [512];
    assign cs_data = rom[cs_addr];

    mic_microsequencer #(.ADDR_W(9), .UI_W(36), .HALT_ADDR(9'h1FF)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .cs_addr   (cs_addr),
        .cs_data   (cs_data),
        .alu_n     (alu_n),
        .alu_z     (alu_z),
        .mbr       (mbr),
        .mem_ready (mem_ready),
        .alu_ctl   (alu_ctl),
        .shift_ctl (shift_ctl),
        .c_en      (c_en),
        .b_sel     (b_sel),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_fetch (mem_fetch),
        .halted    (halted)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [8:0]  addr;
        logic [23:0] ctl;
        logic        hlt;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   total = 0;
    int   bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [35:0] ui(input logic [8:0] na, input logic jmpc, input logic jamn,
                                       input logic jamz, input logic sll8, input logic sra1,
                                       input logic [5:0] alu, input logic [8:0] c, input logic wr,
                                       input logic rd, input logic fe, input logic [3:0] b);
        return {na, jmpc, jamn, jamz, sll8, sra1, alu, c, wr, rd, fe, b};
    endfunction

    // {alu, sll8, sra1, C, B, READ, WRITE, FETCH} as seen on the output pins in EXEC
    function automatic logic [23:0] ctl_of(input logic [35:0] w);
        return {w[21:16], w[23:22], w[15:7], w[3:0], w[5], w[6], w[4]};
    endfunction

    task automatic tick(input string tag, input logic [8:0] addr, input logic [23:0] ctl,
                        input logic hlt);
        @(posedge clk);
        exp_q.push_back('{tag, addr, ctl, hlt});
        #1;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            check({mon_e.tag, ".addr"}, 32'(cs_addr), 32'(mon_e.addr));
            check({mon_e.tag, ".ctl"},
                  32'({alu_ctl, shift_ctl, c_en, b_sel, mem_rd, mem_wr, mem_fetch}),
                  32'(mon_e.ctl));
            check({mon_e.tag, ".halted"}, 32'(halted), 32'(mon_e.hlt));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    logic [35:0] w0, w5, w110, w60, w20, w30, w40, w10;
    localparam logic [23:0] Z = 24'h0;

    initial begin
        for (int i = 0; i < 512; i++) rom[i] = '0;
        w0   = ui(9'h005, 0, 0, 0, 0, 0, 6'b111100, 9'h001, 0, 0, 0, 4'h0);
        w5   = ui(9'h010, 0, 0, 1, 0, 0, 6'b010100, 9'h002, 0, 0, 0, 4'h1);
        w110 = ui(9'h000, 1, 0, 0, 1, 0, 6'b001100, 9'h004, 0, 0, 0, 4'h2);
        w60  = ui(9'h020, 0, 0, 0, 0, 0, 6'b110101, 9'h000, 0, 1, 0, 4'h3);
        w20  = ui(9'h030, 0, 0, 0, 0, 1, 6'b011000, 9'h1AA, 1, 0, 0, 4'h4);
        w30  = ui(9'h040, 0, 1, 1, 0, 0, 6'b111111, 9'h010, 0, 0, 1, 4'h5);
        w40  = ui(9'h07F, 1, 1, 0, 0, 0, 6'b000000, 9'h000, 0, 0, 0, 4'h6);
        w10  = ui(9'h005, 0, 0, 0, 0, 0, 6'b000001, 9'h008, 0, 1, 0, 4'h7);
        rom[9'h000] = w0;   rom[9'h005] = w5;  rom[9'h110] = w110; rom[9'h060] = w60;
        rom[9'h020] = w20;  rom[9'h030] = w30; rom[9'h040] = w40;  rom[9'h010] = w10;

        // reset and idle; mem_ready outside EXEC/WAIT_MEM has no effect
        tick("rst0", 9'h000, Z, 0);
        tick("rst1", 9'h000, Z, 0);
        reset = 1'b0; mem_ready = 1'b1;
        tick("idle", 9'h000, Z, 0);
        mem_ready = 1'b0;

        // basic issue/exec pair, then JAMZ taken
        start = 1'b1; tick("issue0", 9'h000, Z, 0);
        start = 1'b0; tick("exec0", 9'h000, ctl_of(w0), 0);
        tick("issue5", 9'h005, Z, 0);
        tick("exec5", 9'h005, ctl_of(w5), 0);
        alu_z = 1'b1; tick("jamz_taken", 9'h110, Z, 0);
        alu_z = 1'b0; mbr = 8'h60;
        tick("exec110", 9'h110, ctl_of(w110), 0);
        tick("jmpc", 9'h060, Z, 0);
        mbr = 8'h00;

        // read with three stall cycles
        tick("exec60", 9'h060, ctl_of(w60), 0);
        tick("wait1", 9'h020, Z, 0);
        tick("wait2", 9'h020, Z, 0);
        tick("wait3", 9'h020, Z, 0);
        mem_ready = 1'b1; tick("issue20", 9'h020, Z, 0);

        // write completing in EXEC; start mid-run ignored
        tick("exec20", 9'h020, ctl_of(w20), 0);
        start = 1'b1; tick("issue30", 9'h030, Z, 0);
        start = 1'b0; tick("exec30", 9'h030, ctl_of(w30), 0);
        tick("jam_none", 9'h040, Z, 0);

        // 07F | 080 | 100 = 1FF: OR without carry, lands on HALT
        mbr = 8'h80; alu_n = 1'b1;
        tick("exec40", 9'h040, ctl_of(w40), 0);
        tick("halt", 9'h1FF, Z, 1);
        mbr = 8'h00; alu_n = 1'b0;
        tick("halt_hold", 9'h1FF, Z, 1);
        start = 1'b1; tick("restart", 9'h000, Z, 0);
        start = 1'b0; tick("exec0b", 9'h000, ctl_of(w0), 0);
        tick("issue5b", 9'h005, Z, 0);
        tick("exec5b", 9'h005, ctl_of(w5), 0);
        tick("jamz_not", 9'h010, Z, 0);

        // reset during a memory stall; start held with reset is ignored
        mem_ready = 1'b0;
        tick("exec10", 9'h010, ctl_of(w10), 0);
        tick("wait10", 9'h005, Z, 0);
        reset = 1'b1; start = 1'b1;
        tick("rst_wait", 9'h000, Z, 0);
        tick("rst_hold", 9'h000, Z, 0);
        reset = 1'b0; start = 1'b0;
        tick("idle2", 9'h000, Z, 0);
        start = 1'b1; tick("issue_after", 9'h000, Z, 0);
        start = 1'b0; tick("exec_after", 9'h000, ctl_of(w0), 0);

        @(negedge clk);
        #1;
        check("drain", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
